controlador_ascensor: RTL and testbench

Request scheduler and motion sequencer for the four-floor elevator (floors encoded 00 = -1, 01 = 1, 10 = 2, 11 = 3). It latches floor calls and serves them in SCAN order, continuing in the current direction before reversing. It times floor-to-floor travel and the door dwell, and drives the current floor, direction and door status used by the display and floor-transition logic.

---
 rtl/controlador_ascensor.sv | 182 ++++++++++++++++++
 tb/tb_controlador_ascensor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_ascensor.sv
// controlador_ascensor
// Request scheduler and motion sequencer for a four-floor elevator
// (floor encodings 00 = -1, 01 = 1, 10 = 2, 11 = 3). Calls are latched and
// served in SCAN order: keep going in the last travel direction while calls
// remain ahead, then reverse. Floor-to-floor travel and door dwell are timed
// with a shared down-counter.
//
// Ports:
//   clk_nuevo      in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   llamada[3:0]   in   call request, bit i = floor encoding i (level or pulse)
//   piso_actual    out  current floor encoding
//   direccion      out  00 stopped, 01 up, 10 down
//   puerta_abierta out  door open
//   pendientes     out  latched, unserved calls
//   moviendo       out  high while travelling
module controlador_ascensor #(
  parameter int T_PISO   = 100000000,
  parameter int T_PUERTA = 50000000
) (
  input  logic       clk_nuevo,
  input  logic       reset,
  input  logic [3:0] llamada,
  output logic [1:0] piso_actual,
  output logic [1:0] direccion,
  output logic       puerta_abierta,
  output logic [3:0] pendientes,
  output logic       moviendo
);

  localparam logic [26:0] RECARGA_PISO   = 27'(T_PISO - 1);
  localparam logic [26:0] RECARGA_PUERTA = 27'(T_PUERTA - 1);
  localparam logic [1:0]  DIR_PARADO     = 2'b00;
  localparam logic [1:0]  DIR_SUBE       = 2'b01;
  localparam logic [1:0]  DIR_BAJA       = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ANDANDO = 2'd1,
    PUERTA  = 2'd2
  } estado_t;

  estado_t     state_reg, state_next;
  logic [26:0] timer_reg, timer_next;
  logic [1:0]  ult_dir_reg, ult_dir_next;
  logic [1:0]  piso_next;
  logic [1:0]  dir_opuesta;
  logic [1:0]  direccion_next;
  logic        puerta_next;
  logic        moviendo_next;
  logic [3:0]  req;
  logic [3:0]  clr;
  logic [3:0]  pend_next;

  // Floors strictly above p.
  function automatic logic [3:0] sobre(input logic [1:0] p);
    logic [3:0] m;
    m = 4'b1110;
    return m << p;
  endfunction

  // Floors strictly below p.
  function automatic logic [3:0] bajo(input logic [1:0] p);
    logic [3:0] m;
    m = 4'b1111;
    return ~(m << p);
  endfunction

  function automatic logic [3:0] un_piso(input logic [1:0] p);
    logic [3:0] m;
    m = 4'b0001;
    return m << p;
  endfunction

  // Floors lying ahead of p when travelling in direction dir.
  function automatic logic [3:0] delante(input logic [1:0] dir, input logic [1:0] p);
    return (dir == DIR_SUBE) ? sobre(p) : bajo(p);
  endfunction

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    ult_dir_next   = ult_dir_reg;
    piso_next      = piso_actual;
    direccion_next = DIR_PARADO;
    puerta_next    = 1'b0;
    moviendo_next  = 1'b0;
    clr            = 4'b0000;
    // Decisions see this cycle's calls too, so a call is acted on at the
    // same edge that latches it.
    req            = pendientes | llamada;
    dir_opuesta    = (ult_dir_reg == DIR_SUBE) ? DIR_BAJA : DIR_SUBE;

    case (state_reg)
      IDLE: begin
        if ((req & un_piso(piso_actual)) != 4'b0000) begin
          state_next = PUERTA;
          timer_next = RECARGA_PUERTA;
        end else if ((req & delante(ult_dir_reg, piso_actual)) != 4'b0000) begin
          state_next = ANDANDO;
          timer_next = RECARGA_PISO;
        end else if ((req & delante(dir_opuesta, piso_actual)) != 4'b0000) begin
          state_next   = ANDANDO;
          ult_dir_next = dir_opuesta;
          timer_next   = RECARGA_PISO;
        end
      end

      ANDANDO: begin
        if (timer_reg != 27'd0) begin
          timer_next = timer_reg - 27'd1;
        end else if ((ult_dir_reg == DIR_SUBE && piso_actual == 2'b11) ||
                     (ult_dir_reg == DIR_BAJA && piso_actual == 2'b00)) begin
          // Out-of-range step is refused rather than wrapped.
          state_next = IDLE;
        end else begin
          piso_next = (ult_dir_reg == DIR_SUBE) ? piso_actual + 2'd1
                                                : piso_actual - 2'd1;
          // Arrival decisions are taken against the floor being entered.
          if ((req & un_piso(piso_next)) != 4'b0000) begin
            state_next = PUERTA;
            timer_next = RECARGA_PUERTA;
          end else if ((req & delante(ult_dir_reg, piso_next)) != 4'b0000) begin
            timer_next = RECARGA_PISO;
          end else begin
            state_next = IDLE;
          end
        end
      end

      PUERTA: begin
        // A fresh call for this floor keeps the door open.
        if (llamada[piso_actual]) begin
          timer_next = RECARGA_PUERTA;
        end else if (timer_reg == 27'd0) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg - 27'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // The floor being served (or about to be) is never left pending.
    if (state_reg == PUERTA || state_next == PUERTA) begin
      clr = un_piso(piso_next);
    end
    pend_next = req & ~clr;

    if (state_next == ANDANDO) begin
      direccion_next = ult_dir_next;
      moviendo_next  = 1'b1;
    end
    puerta_next = (state_next == PUERTA);
  end

  always_ff @(posedge clk_nuevo or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      timer_reg      <= 27'd0;
      ult_dir_reg    <= DIR_SUBE;
      piso_actual    <= 2'b01;
      direccion      <= DIR_PARADO;
      puerta_abierta <= 1'b0;
      pendientes     <= 4'b0000;
      moviendo       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      ult_dir_reg    <= ult_dir_next;
      piso_actual    <= piso_next;
      direccion      <= direccion_next;
      puerta_abierta <= puerta_next;
      pendientes     <= pend_next;
      moviendo       <= moviendo_next;
    end
  end

endmodule

// File: tb/tb_controlador_ascensor.sv
// Testbench for controlador_ascensor. A floor-level reference model turns the
// applied calls into a queue of expected observable events (floor change,
// door open/close, departure, stop), each stamped with its clock edge and the
// expected pending mask. A separate monitor detects those events on the DUT
// outputs and checks them against the queue in order.
module tb_controlador_ascensor;

  localparam int T_PISO   = 4;
  localparam int T_PUERTA = 3;

  logic       clk;
  logic       rst;
  logic [3:0] llamada;
  logic [1:0] piso_actual;
  logic [1:0] direccion;
  logic       puerta_abierta;
  logic [3:0] pendientes;
  logic       moviendo;

  controlador_ascensor #(
    .T_PISO   (T_PISO),
    .T_PUERTA (T_PUERTA)
  ) dut (
    .clk_nuevo      (clk),
    .reset          (rst),
    .llamada        (llamada),
    .piso_actual    (piso_actual),
    .direccion      (direccion),
    .puerta_abierta (puerta_abierta),
    .pendientes     (pendientes),
    .moviendo       (moviendo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 floor, 1 door open, 2 door close, 3 depart, 4 stop
    int         data;   // floor, or direction code
    int         stamp;  // edge index
    logic [3:0] pend;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  edge_cnt = 0;

  // Reference model: floor as an integer, direction as +1/-1, mode
  // 0 idle / 1 travelling / 2 door open, and a count of edges left until
  // the current travel leg or dwell ends.
  int         m_floor;
  int         m_dir;
  int         m_mode;
  int         m_left;
  logic [3:0] m_pend;

  function automatic bit hay_delante(input int floor, input int dir, input logic [3:0] mask);
    for (int f = 0; f < 4; f++) begin
      if (mask[f] && (f - floor) * dir > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 1;
    m_dir   = 1;
    m_mode  = 0;
    m_left  = 0;
    m_pend  = 4'b0000;
  endtask

  task automatic push(input int kind, input int data);
    ev_t e;
    e.kind  = kind;
    e.data  = data;
    e.stamp = edge_cnt;
    e.pend  = m_pend;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input logic [3:0] c);
    logic [3:0] req;
    int prev_mode;
    int old_floor;
    req       = m_pend | c;
    prev_mode = m_mode;
    old_floor = m_floor;
    case (m_mode)
      0: begin
        if (req[m_floor]) begin
          m_mode = 2; m_left = T_PUERTA;
        end else if (hay_delante(m_floor, m_dir, req)) begin
          m_mode = 1; m_left = T_PISO;
        end else if (hay_delante(m_floor, -m_dir, req)) begin
          m_dir = -m_dir; m_mode = 1; m_left = T_PISO;
        end
      end
      1: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_floor + m_dir < 0 || m_floor + m_dir > 3) begin
            m_mode = 0;
          end else begin
            m_floor = m_floor + m_dir;
            if (req[m_floor]) begin
              m_mode = 2; m_left = T_PUERTA;
            end else if (hay_delante(m_floor, m_dir, req)) begin
              m_left = T_PISO;
            end else begin
              m_mode = 0;
            end
          end
        end
      end
      default: begin
        if (c[m_floor]) begin
          m_left = T_PUERTA;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 0;
        end
      end
    endcase
    m_pend = req;
    if (prev_mode == 2 || m_mode == 2) m_pend[m_floor] = 1'b0;

    if (m_floor != old_floor)        push(0, m_floor);
    if (m_mode == 2 && prev_mode != 2) push(1, m_floor);
    if (prev_mode == 2 && m_mode != 2) push(2, m_floor);
    if (m_mode == 1 && prev_mode != 1) push(3, (m_dir > 0) ? 1 : 2);
    if (prev_mode == 1 && m_mode != 1) push(4, 0);
  endtask

  // One clock cycle: present the call, then advance the model on the edge.
  task automatic tick(input logic [3:0] c);
    @(negedge clk);
    llamada = c;
    @(posedge clk);
    edge_cnt = edge_cnt + 1;
    if (!rst) model_step(c);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end else begin
      $display("check %s = %0d", name, got);
    end
  endtask

  // ---------------- monitor ----------------
  logic [1:0] p_piso;
  logic       p_puerta;
  logic       p_mov;

  task automatic observar(input int kind, input int data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind %0d data %0d edge %0d pend %b, none required",
               kind, data, edge_cnt, pendientes);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data != data || e.stamp != edge_cnt || e.pend !== pendientes) begin
        errors++;
        $display("FAIL event got kind %0d data %0d edge %0d pend %b required kind %0d data %0d edge %0d pend %b",
                 kind, data, edge_cnt, pendientes, e.kind, e.data, e.stamp, e.pend);
      end else begin
        $display("event kind %0d data %0d edge %0d pend %b", kind, data, edge_cnt, pendientes);
      end
    end
  endtask

  initial begin
    p_piso   = 2'b01;
    p_puerta = 1'b0;
    p_mov    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_piso   = 2'b01;
        p_puerta = 1'b0;
        p_mov    = 1'b0;
      end else begin
        if (piso_actual != p_piso)       observar(0, int'(piso_actual));
        if (puerta_abierta && !p_puerta) observar(1, int'(piso_actual));
        if (!puerta_abierta && p_puerta) observar(2, int'(piso_actual));
        if (moviendo && !p_mov)          observar(3, int'(direccion));
        if (!moviendo && p_mov)          observar(4, int'(direccion));
        p_piso   = piso_actual;
        p_puerta = puerta_abierta;
        p_mov    = moviendo;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] d_call [12] = '{4'b1000, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0100,
                              4'b0100, 4'b0010, 4'b0100, 4'b1001, 4'b1000, 4'b0001};
  int         d_len  [12] = '{14, 16, 2, 8, 2, 20, 12, 12, 12, 40, 14, 30};

  task automatic random_phase(input int n);
    logic [3:0] c;
    int hold;
    int i;
    i = 0;
    while (i < n) begin
      if ($urandom_range(0, 7) == 0) begin
        c    = 4'($urandom_range(1, 15));
        hold = $urandom_range(1, 4);
        for (int k = 0; k < hold; k++) tick(c);
        i = i + hold;
      end else begin
        tick(4'b0000);
        i = i + 1;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && !(m_mode == 0 && m_pend == 4'b0000); i++) tick(4'b0000);
    tick(4'b0000);
  endtask

  initial begin
    logic [3:0] c;
    rst     = 1'b1;
    llamada = 4'b0000;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_piso", int'(piso_actual), 1);
    chk("reset_direccion", int'(direccion), 0);
    chk("reset_puerta", int'(puerta_abierta), 0);
    chk("reset_pendientes", int'(pendientes), 0);
    chk("reset_moviendo", int'(moviendo), 0);
    rst = 1'b0;

    for (int s = 0; s < 12; s++) begin
      tick(d_call[s]);
      for (int k = 1; k < d_len[s]; k++) tick(4'b0000);
    end

    random_phase(400);
    drain();

    // Reset while travelling: send a call two floors away, then abort.
    c = 4'b0001 << ((m_floor + 2) % 4);
    tick(c);
    tick(4'b0000);
    @(negedge clk);
    chk("moviendo_before_reset", int'(moviendo), (m_mode == 1) ? 1 : 0);
    #2 rst = 1'b1;
    #1;
    chk("midrun_reset_piso", int'(piso_actual), 1);
    chk("midrun_reset_direccion", int'(direccion), 0);
    chk("midrun_reset_puerta", int'(puerta_abierta), 0);
    chk("midrun_reset_pendientes", int'(pendientes), 0);
    chk("midrun_reset_moviendo", int'(moviendo), 0);
    model_reset();
    exp_q.delete();
    tick(4'b0000);
    tick(4'b0000);
    @(negedge clk);
    rst = 1'b0;

    random_phase(400);
    drain();
    repeat (5) tick(4'b0000);
    @(negedge clk);
    chk("events_outstanding", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
